// File: rtl/div_unit.sv
// Iterative integer divider for div/divu/rem/remu: one restoring-divide quotient bit per clock.
// Divide-by-zero and signed overflow complete without iterating. Flush and reset abandon the operation.
module div_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     src1,
  input  logic [DATA_WIDTH-1:0]     src2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     gpr_w,
  output logic [REG_ADDR_WIDTH-1:0] gpr_w_addr,
  output logic                      gpr_w_en,
  output logic                      busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]     r_quot;
  logic [DATA_WIDTH-1:0]     r_rem;
  logic [DATA_WIDTH-1:0]     r_divisor;
  logic                      r_sel_rem;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_neg_q;
  logic                      r_neg_r;

  logic                      w_accept;
  logic                      w_signed;
  logic                      w_a_neg;
  logic                      w_b_neg;
  logic                      w_div_zero;
  logic                      w_overflow;
  logic [DATA_WIDTH-1:0]     w_a_mag;
  logic [DATA_WIDTH-1:0]     w_b_mag;
  logic [DATA_WIDTH:0]       w_trial;
  logic [DATA_WIDTH-1:0]     w_shifted;
  logic                      w_qbit;
  logic [DATA_WIDTH-1:0]     w_quot_res;
  logic [DATA_WIDTH-1:0]     w_rem_res;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign w_accept   = in_valid && in_ready && !flush;
  assign w_signed   = !op[0];
  assign w_a_neg    = w_signed && src1[DATA_WIDTH-1];
  assign w_b_neg    = w_signed && src2[DATA_WIDTH-1];
  assign w_a_mag    = cond_neg(src1, w_a_neg);
  assign w_b_mag    = cond_neg(src2, w_b_neg);
  assign w_div_zero = (src2 == '0);
  assign w_overflow = w_signed && (src1 == MOST_NEG) && (src2 == '1);

  // r_quot doubles as the dividend shift register; quotient bits enter at the LSB.
  assign w_shifted = {r_rem[DATA_WIDTH-2:0], r_quot[DATA_WIDTH-1]};
  assign w_trial   = {r_rem, r_quot[DATA_WIDTH-1]} - {1'b0, r_divisor};
  assign w_qbit    = !w_trial[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_sel_rem <= 1'b0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sel_rem <= op[1];
            r_rd      <= rd;
            r_cnt     <= LAST_CNT;
            if (w_div_zero) begin
              r_quot  <= '1;
              r_rem   <= src1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= DONE;
            end else if (w_overflow) begin
              r_quot  <= src1;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= DONE;
            end else begin
              r_quot    <= w_a_mag;
              r_rem     <= '0;
              r_divisor <= w_b_mag;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_state   <= CALC;
            end
          end
        end
        CALC: begin
          r_quot <= {r_quot[DATA_WIDTH-2:0], w_qbit};
          r_rem  <= w_qbit ? w_trial[DATA_WIDTH-1:0] : w_shifted;
          r_cnt  <= r_cnt - CNT_ONE;
          if (r_cnt == '0) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sign fix-up is applied on the way out; special cases store flags cleared.
  assign w_quot_res = cond_neg(r_quot, r_neg_q);
  assign w_rem_res  = cond_neg(r_rem, r_neg_r);

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign gpr_w_en   = (r_state == DONE) && (r_rd != '0) && !flush;
  assign gpr_w      = (r_state == DONE) ? (r_sel_rem ? w_rem_res : w_quot_res) : '0;
  assign gpr_w_addr = (r_state == DONE) ? r_rd : '0;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operations against a plain-arithmetic
// RISC-V division model, checking data, address, pulse timing, flush and reset behaviour.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  rd;
  logic        flush;
  logic [31:0] gpr_w;
  logic [4:0]  gpr_w_addr;
  logic        gpr_w_en;
  logic        busy;

  int errors = 0;
  int checks = 0;

  div_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .rd         (rd),
    .flush      (flush),
    .gpr_w      (gpr_w),
    .gpr_w_addr (gpr_w_addr),
    .gpr_w_en   (gpr_w_en),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next posedge and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input bit hammer,
                        input string tag);
    int lat;
    bit early;
    lat   = ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 32;
    early = 1'b0;
    in_valid = 1'b1; op = o; src1 = a; src2 = b; rd = r;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = $urandom; src2 = $urandom;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int j = 0; j <= lat + 1; j++) begin
      @(negedge clk);
      if (j < lat) begin
        early |= gpr_w_en;
        if (hammer) begin
          in_valid = 1'b1; op = 2'($urandom); src1 = $urandom; src2 = $urandom; rd = 5'($urandom);
        end
      end else if (j == lat) begin
        in_valid = 1'b0;
        chk({tag, "_early_en"}, {31'd0, early}, 32'd0);
        chk({tag, "_en"}, {31'd0, gpr_w_en}, {31'd0, (r != 5'd0)});
        chk({tag, "_data"}, gpr_w, exp);
        chk({tag, "_addr"}, {27'd0, gpr_w_addr}, {27'd0, r});
      end else begin
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_en"}, {31'd0, gpr_w_en}, 32'd0);
        chk({tag, "_idle_w"}, gpr_w, 32'd0);
      end
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b1; op = 2'b01; src1 = 32'd50; src2 = 32'd5; rd = 5'd7; flush = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_en", {31'd0, gpr_w_en}, 32'd0);
    chk("rst_w", gpr_w, 32'd0);
    chk("rst_addr", {27'd0, gpr_w_addr}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_no_accept", {31'd0, busy}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b1, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 1'b0, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 1'b1, "rem_m7_2");
    run_op(2'b01, 32'h0000_1234, 32'd0, 5'd3, 32'hFFFF_FFFF, 1'b0, "divu_by0");
    run_op(2'b11, 32'h0000_1234, 32'd0, 5'd3, 32'h0000_1234, 1'b0, "remu_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'd0, 1'b0, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'd0, 1'b0, "divu_big");
    run_op(2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 1'b0, "divu_rd0");

    // Request presented together with flush must be dropped.
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; src1 = 32'd8; src2 = 32'd2; rd = 5'd4;
    @(negedge clk);
    chk("flush_idle_reject", {31'd0, busy}, 32'd0);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Flush at edge k+10 of a normal divide, then a fresh request at the next edge.
    seen = 1'b0;
    in_valid = 1'b1; op = 2'b01; src1 = 32'd1000; src2 = 32'd3; rd = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      seen |= gpr_w_en;
      if (j == 9) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_calc_no_en", {31'd0, seen}, 32'd0);
    chk("flush_calc_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_calc_busy", {31'd0, busy}, 32'd0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FFF2, 1'b0, "after_flush");

    // Flush while in DONE masks the writeback pulse in that same cycle.
    in_valid = 1'b1; op = 2'b01; src1 = 32'd77; src2 = 32'd0; rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_en_before_flush", {31'd0, gpr_w_en}, 32'd1);
    flush = 1'b1;
    #1;
    chk("done_flush_mask", {31'd0, gpr_w_en}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-CALC, between edges k+15 and k+16.
    seen = 1'b0;
    in_valid = 1'b1; op = 2'b11; src1 = 32'd12345; src2 = 32'd100; rd = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      seen |= gpr_w_en;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_en", {31'd0, gpr_w_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 17; j <= 41; j++) begin
      @(negedge clk);
      seen |= gpr_w_en;
    end
    chk("rst_mid_no_pulse", {31'd0, seen}, 32'd0);
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      o = 2'($urandom);
      a = $urandom;
      r = 5'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      run_op(o, a, b, r, ref_div(o, a, b), bit'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
